// File: rtl/serializer.sv
// Parallel-to-serial byte transmitter: small byte FIFO feeding an MSB-first
// bit shifter with a per-bit write strobe and receiver-driven flow control.
module serializer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write_in,
    output logic       status_out,
    output logic       data_out,
    output logic       write_out,
    input  logic       status_in,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [2:0]    bitcnt_q;
    logic          data_q;
    logic          wr_q;
    logic          ovf_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO refuses writes even when a pop frees a slot on the same edge.
    assign push  = write_in && !full;
    assign pop   = (state_q == IDLE) && !empty && status_in;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (write_in && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q  <= mem_q[rptr_q];
                        data_q   <= mem_q[rptr_q][7];
                        wr_q     <= 1'b1;
                        bitcnt_q <= '0;
                        state_q  <= SHIFT;
                    end else begin
                        wr_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    // write_out is always high here, so status_in alone marks a transfer.
                    if (status_in) begin
                        if (bitcnt_q == 3'd7) begin
                            wr_q    <= 1'b0;
                            data_q  <= 1'b0;
                            state_q <= GAP;
                        end else begin
                            shreg_q  <= {shreg_q[6:0], 1'b0};
                            data_q   <= shreg_q[6];
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign status_out = !full;
    assign data_out   = data_q;
    assign write_out  = wr_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = ovf_q;

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter. It accepts bytes from a local producer into a small FIFO and shifts each byte out MSB-first as a bit stream with a per-bit write strobe. Downstream flow control comes from the receiving deserializer's status line. The block sits upstream of the `deserializer` and drives its `data_in`, `write_in` and `status_out` pins one-to-one, so the pair forms a complete byte link in the `clk_100mhz` domain.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of 2, at least 2.
- `clk_100mhz`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge at which it is sampled high.
- `data_in`  in  8  byte to transmit.
- `write_in`  in  1  byte strobe. Each edge with `write_in`=1 and `status_out`=1 enqueues `data_in`.
- `status_out`  out  1  1 = FIFO not full (can accept a byte); combinational from the occupancy count.
- `data_out`  out  1  serial bit to the receiver (its `data_in`). Registered.
- `write_out`  out  1  bit-valid strobe to the receiver (its `write_in`). Registered.
- `status_in`  in  1  receiver ready (its `status_out`).
- `busy`  out  1  1 while a byte is in flight (states SHIFT or GAP).
- `overflow`  out  1  sticky. Set when `write_in`=1 while `status_out`=0; cleared only by `reset`.

## Operation
- FIFO: circular buffer with `$clog2(FIFO_DEPTH)+1`-bit count, and read/write pointers that wrap modulo `FIFO_DEPTH`. First-in first-out order is preserved.
- States:
  - IDLE: `write_out`=0. If FIFO is non-empty and `status_in`=1 at an edge:
    - pop the head byte into an 8-bit shift register;
    - drive `data_out`=bit7 and `write_out`=1;
    - set bit counter to 0;
    - go to SHIFT.
  - SHIFT: a bit transfers at each edge where `write_out`=1 and `status_in`=1.
    - On transfer with counter < 7: shift left, present the next bit, increment the counter, keep `write_out`=1.
    - On transfer with counter = 7: `write_out`=0, `data_out`=0, go to GAP.
    - If `status_in`=0: hold `data_out`, `write_out` and the counter unchanged (back-pressure).
  - GAP: exactly one cycle with `write_out`=0, then go to IDLE. This lets the receiver's registered `status_out` fall after a full byte before the next start.
- Bit order: MSB first. Byte 0x55 appears on `data_out` as 0,1,0,1,0,1,0,1.
- Simultaneous push and pop:
  - Allowed when not full. Count is unchanged; both pointers advance.
  - When full, `write_in` is ignored even if a pop occurs on the same edge, and `overflow` is set.
- Reset mid-operation:
  - FIFO is emptied and the state returns to IDLE.
  - The partial byte is discarded, never resumed.
  - `write_out` is 0 from the reset edge onward.
- Reset values: `data_out`=0, `write_out`=0, `busy`=0, `overflow`=0, `status_out`=1 (FIFO empty).

## Timing
- Accept-to-first-bit latency is 1 cycle. If `write_in` is sampled at edge E0 with an empty FIFO and IDLE, and `status_in`=1 at E1, then the first bit and `write_out` are valid from E1.
- Unstalled byte: 8 consecutive `write_out` cycles, then 1 GAP cycle, then 1 IDLE cycle before the next byte's first bit. Back-to-back bytes therefore occupy 10 cycles each.
- Each stall cycle (`status_in`=0 in SHIFT) adds exactly 1 cycle. `data_out` is stable throughout a stall.
- `status_out` rises in the cycle after the pop edge that frees a full FIFO.
- `busy` rises with the first `write_out` and falls at the GAP→IDLE edge.

## Test plan
- Single byte: reset, then write 0x55 with `status_in`=1.
  - Expect `write_out`=1 for 8 consecutive cycles starting one cycle after accept.
  - Expect `data_out`=0,1,0,1,0,1,0,1.
  - Expect `busy`=1 for 9 cycles, then `write_out`=0.
- Back-pressure: send 0xA5 and drop `status_in` for 4 cycles after the 3rd bit transfers.
  - Expect bit3 (0) held with `write_out`=1 during the stall.
  - Expect exactly 8 transfers total, bits 1,0,1,0,0,1,0,1.
- FIFO full: with `status_in`=0, write 0x11, 0x22, 0x33, 0x44, then 0x55.
  - Expect `status_out`=0 after the 4th write, the 5th write dropped, and `overflow`=1.
  - Release `status_in`. Expect 0x11, 0x22, 0x33, 0x44 serialized in order, with `status_out`=1 one cycle after the first pop.
- Loopback: connect to `deserializer`, send 0xA5 then 0x3C, and pulse `ack_in` one cycle after each `data_ready`.
  - Expect `data_out` of the receiver to be 0xA5 then 0x3C.
  - Expect no bit transferred while the receiver's `status_out`=0.
- Reset mid-byte: assert `reset` for 1 cycle after 4 bits of 0xFF, with 2 more bytes queued.
  - Expect `write_out`=0, `busy`=0, `status_out`=1 and `overflow`=0 from the reset edge.
  - Expect no further strobes until a new write.
